// File: rtl/uart_rx_frame.sv
// uart_rx_frame
//   UART receiver: synchronises the serial line, finds the start bit, samples
//   each data/parity/stop bit in the middle of its bit time and presents the
//   received payload on an AXI-Stream master with a parity-error flag in tuser.
//
//   Handshake: m_axis_tvalid rises with a new byte and holds tdata/tuser stable
//   until a cycle where m_axis_tvalid & m_axis_tready are both 1; the byte is
//   consumed on that clock edge.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   rx_en           receiver enable; 0 returns the FSM to IDLE (frame discarded)
//   rx              asynchronous serial line, idle high
//   m_axis_tready   downstream ready
//   m_axis_tdata    received payload (LSB received first)
//   m_axis_tvalid   payload valid
//   m_axis_tuser    parity error on this byte (0 when parity is disabled)
//   frame_err       1-cycle pulse: stop bit sampled low, byte discarded
//   overrun         1-cycle pulse: byte completed while output still held, byte dropped
//   dbg_state       current FSM state (state_t encoding)
module uart_rx_frame #(
  parameter int system_clk = 50000000,
  parameter int band_rate  = 115200,
  parameter int data_bits  = 8,
  parameter int check_mode = 1,
  parameter int stop_mode  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 rx,
  input  logic                 m_axis_tready,
  output logic [data_bits-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tuser,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [2:0]           dbg_state
);

  localparam int DIV   = system_clk / band_rate;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_STOP2  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q, rs_d_q;
  logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [data_bits-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic [data_bits-1:0] tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tuser_q, tuser_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 deliver;
  logic                 rs;
  logic                 sample_mid, sample_full;

  assign rs          = sync2_q;
  assign sample_mid  = (baud_cnt_q == CNT_W'(HALF - 1));
  assign sample_full = (baud_cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tuser_d     = tuser_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;

    if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        // Falling edge of the synchronised line marks a candidate start bit.
        if (rx_en && rs_d_q && !rs) state_d = S_START;
      end
      S_START: begin
        if (sample_mid) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          perr_d     = 1'b0;
          // Line back high at mid start bit: it was a glitch.
          state_d    = rs ? S_IDLE : S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (sample_full) begin
          baud_cnt_d = '0;
          shift_d    = {rs, shift_q[data_bits-1:1]};
          if (bit_cnt_q == BIT_W'(data_bits - 1)) begin
            bit_cnt_d = '0;
            state_d   = (check_mode != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (sample_full) begin
          baud_cnt_d = '0;
          // Odd parity expects an odd count of ones over data+parity.
          perr_d     = ((^shift_q) ^ rs) != (check_mode == 1);
          state_d    = S_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      S_STOP, S_STOP2: begin
        if (sample_full) begin
          baud_cnt_d = '0;
          if (!rs) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end else if (state_q == S_STOP && stop_mode == 1) begin
            state_d = S_STOP2;
          end else begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        baud_cnt_d = '0;
      end
    endcase

    // Disable aborts any frame in progress; the output register is left alone.
    if (!rx_en) begin
      state_d     = S_IDLE;
      baud_cnt_d  = '0;
      deliver     = 1'b0;
      frame_err_d = 1'b0;
    end

    // A new byte loads unless the previous one is still held and not being taken.
    if (deliver) begin
      if (tvalid_q && !m_axis_tready) begin
        overrun_d = 1'b1;
      end else begin
        tdata_d  = shift_q;
        tuser_d  = (check_mode != 0) ? perr_q : 1'b0;
        tvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rs_d_q      <= 1'b1;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tuser_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      rs_d_q      <= sync2_q;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      perr_q      <= perr_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tuser_q     <= tuser_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tuser  = tuser_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;
  assign dbg_state     = state_q;

endmodule
